// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router control path: state codes, destination
// addresses and the per-address FIFO-empty selector.
package router_pkg;

  typedef enum logic [3:0] {
    DA  = 4'd0,  // DECODE_ADDRESS
    LFD = 4'd1,  // LOAD_FIRST_DATA
    LD  = 4'd2,  // LOAD_DATA
    WTE = 4'd3,  // WAIT_TILL_EMPTY
    FFS = 4'd4,  // FIFO_FULL_STATE
    LAF = 4'd5,  // LOAD_AFTER_FULL
    LP  = 4'd6,  // LOAD_PARITY
    CPE = 4'd7   // CHECK_PARITY_ERROR
  } state_e;

  localparam logic [1:0] ADDR0 = 2'd0;
  localparam logic [1:0] ADDR1 = 2'd1;
  localparam logic [1:0] ADDR2 = 2'd2;

  // Address 3 has no FIFO behind it, so it never reports empty.
  function automatic logic sel_empty(input logic [1:0] addr, input logic [2:0] empty);
    logic res;
    case (addr)
      ADDR0:   res = empty[0];
      ADDR1:   res = empty[1];
      ADDR2:   res = empty[2];
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/router_ctrl_fsm_if.sv
// Signal bundle between the router control FSM and its surroundings
// (packet source, destination FIFOs, register block).
interface router_ctrl_fsm_if;

  logic       packet_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0;
  logic       fifo_empty_1;
  logic       fifo_empty_2;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;
  logic       parity_done;
  logic       low_packet_valid;

  logic       write_enb_reg;
  logic       detect_add;
  logic       ld_state;
  logic       laf_state;
  logic       lfd_state;
  logic       full_state;
  logic       rst_int_reg;
  logic       busy;
  logic [3:0] present_state;
  logic [3:0] next_state;

  // FSM side
  modport slave (
    input  packet_valid, data_in, fifo_full,
    input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
    input  soft_reset_0, soft_reset_1, soft_reset_2,
    input  parity_done, low_packet_valid,
    output write_enb_reg, detect_add, ld_state, laf_state, lfd_state,
    output full_state, rst_int_reg, busy, present_state, next_state
  );

  // Environment side
  modport master (
    output packet_valid, data_in, fifo_full,
    output fifo_empty_0, fifo_empty_1, fifo_empty_2,
    output soft_reset_0, soft_reset_1, soft_reset_2,
    output parity_done, low_packet_valid,
    input  write_enb_reg, detect_add, ld_state, laf_state, lfd_state,
    input  full_state, rst_int_reg, busy, present_state, next_state
  );

endinterface

// File: rtl/router_ctrl_fsm.sv
// Control FSM of the 1x3 packet router: decodes the header address, sequences
// header/payload/parity loading and handles full stalls and busy destinations.
module router_ctrl_fsm
  import router_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  router_ctrl_fsm_if.slave   bus
);

  logic [3:0] state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [2:0] empty_vec;
  logic       soft_any;

  assign empty_vec = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
  assign soft_any  = bus.soft_reset_0 | bus.soft_reset_1 | bus.soft_reset_2;

  // The header address is latched so WTE keeps watching the right FIFO even
  // after the source moves on to payload bytes.
  assign addr_d = (state_q == DA && bus.packet_valid) ? bus.data_in : addr_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= DA;
      addr_q  <= ADDR0;
    end else begin
      state_q <= soft_any ? DA : state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = DA;
    case (state_q)
      DA: begin
        if (bus.packet_valid && bus.data_in != 2'd3)
          state_d = sel_empty(bus.data_in, empty_vec) ? LFD : WTE;
        else
          state_d = DA;
      end
      LFD: state_d = LD;
      LD: begin
        if (bus.fifo_full)          state_d = FFS;
        else if (!bus.packet_valid) state_d = LP;
        else                        state_d = LD;
      end
      WTE: state_d = sel_empty(addr_q, empty_vec) ? LFD : WTE;
      FFS: state_d = bus.fifo_full ? FFS : LAF;
      LAF: begin
        if (bus.parity_done)           state_d = DA;
        else if (bus.low_packet_valid) state_d = LP;
        else                           state_d = LD;
      end
      LP:  state_d = CPE;
      CPE: state_d = bus.fifo_full ? FFS : DA;
      default: state_d = DA;
    endcase
  end

  always_comb begin
    bus.detect_add    = 1'b0;
    bus.lfd_state     = 1'b0;
    bus.ld_state      = 1'b0;
    bus.laf_state     = 1'b0;
    bus.full_state    = 1'b0;
    bus.rst_int_reg   = 1'b0;
    bus.write_enb_reg = 1'b0;
    bus.busy          = 1'b0;
    case (state_q)
      DA:  bus.detect_add = 1'b1;
      LFD: begin
        bus.lfd_state = 1'b1;
        bus.busy      = 1'b1;
      end
      LD: begin
        bus.ld_state      = 1'b1;
        bus.write_enb_reg = 1'b1;
      end
      WTE: bus.busy = 1'b1;
      FFS: begin
        bus.full_state = 1'b1;
        bus.busy       = 1'b1;
      end
      LAF: begin
        bus.laf_state     = 1'b1;
        bus.write_enb_reg = 1'b1;
        bus.busy          = 1'b1;
      end
      LP: begin
        bus.write_enb_reg = 1'b1;
        bus.busy          = 1'b1;
      end
      CPE: begin
        bus.rst_int_reg = 1'b1;
        bus.busy        = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.present_state = state_q;
  assign bus.next_state    = state_d;

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Directed bench for router_ctrl_fsm: walks every transition with
// hand-computed expected state codes and strobes.
module tb_router_ctrl_fsm;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  router_ctrl_fsm_if bus ();

  router_ctrl_fsm dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Advance one clock and sample 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_state(input string tag, input logic [3:0] exp);
    step();
    check(tag, 32'(bus.present_state), 32'(exp));
  endtask

  task automatic idle_inputs();
    bus.packet_valid     = 1'b0;
    bus.data_in          = 2'd0;
    bus.fifo_full        = 1'b0;
    bus.fifo_empty_0     = 1'b1;
    bus.fifo_empty_1     = 1'b1;
    bus.fifo_empty_2     = 1'b1;
    bus.soft_reset_0     = 1'b0;
    bus.soft_reset_1     = 1'b0;
    bus.soft_reset_2     = 1'b0;
    bus.parity_done      = 1'b0;
    bus.low_packet_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    resetn = 1'b0;

    // Reset
    step();
    check("rst_state", 32'(bus.present_state), 0);
    check("rst_detect_add", 32'(bus.detect_add), 1);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_wen", 32'(bus.write_enb_reg), 0);
    resetn = 1'b1;
    step_state("idle_hold", 4'd0);
    check("idle_ld", 32'(bus.ld_state), 0);

    // Short packet to address 1
    bus.packet_valid = 1'b1;
    bus.data_in      = 2'd1;
    #1 check("da_next", 32'(bus.next_state), 1);
    step_state("p1_lfd", 4'd1);
    check("p1_lfd_strobe", 32'(bus.lfd_state), 1);
    check("p1_lfd_busy", 32'(bus.busy), 1);
    step_state("p1_ld", 4'd2);
    check("p1_ld_wen", 32'(bus.write_enb_reg), 1);
    check("p1_ld_busy", 32'(bus.busy), 0);
    bus.packet_valid = 1'b0;
    step_state("p1_lp", 4'd6);
    check("p1_lp_wen", 32'(bus.write_enb_reg), 1);
    step_state("p1_cpe", 4'd7);
    check("p1_cpe_rst_int", 32'(bus.rst_int_reg), 1);
    step_state("p1_da", 4'd0);

    // Busy destination: latched address 2 must be watched, not data_in
    bus.packet_valid = 1'b1;
    bus.data_in      = 2'd2;
    bus.fifo_empty_2 = 1'b0;
    step_state("wte_enter", 4'd3);
    check("wte_busy", 32'(bus.busy), 1);
    bus.data_in = 2'd0;
    step_state("wte_hold", 4'd3);
    bus.fifo_empty_2 = 1'b1;
    step_state("wte_lfd", 4'd1);
    step_state("wte_ld", 4'd2);

    // Full stall -> LAF -> LP (low_packet_valid)
    bus.fifo_full = 1'b1;
    step_state("ffs_enter", 4'd4);
    check("ffs_strobe", 32'(bus.full_state), 1);
    check("ffs_wen", 32'(bus.write_enb_reg), 0);
    step_state("ffs_hold", 4'd4);
    bus.fifo_full = 1'b0;
    step_state("laf_enter", 4'd5);
    check("laf_strobe", 32'(bus.laf_state), 1);
    check("laf_wen", 32'(bus.write_enb_reg), 1);
    bus.low_packet_valid = 1'b1;
    step_state("laf_lp", 4'd6);
    bus.low_packet_valid = 1'b0;
    bus.packet_valid     = 1'b0;
    step_state("laf_lp_cpe", 4'd7);
    step_state("laf_lp_da", 4'd0);

    // LAF -> LD, then LAF -> DA on parity_done
    bus.packet_valid = 1'b1;
    bus.data_in      = 2'd0;
    step_state("p0_lfd", 4'd1);
    step_state("p0_ld", 4'd2);
    bus.fifo_full = 1'b1;
    step_state("p0_ffs", 4'd4);
    bus.fifo_full = 1'b0;
    step_state("p0_laf", 4'd5);
    step_state("laf_ld", 4'd2);
    bus.fifo_full = 1'b1;
    step_state("p0_ffs2", 4'd4);
    bus.fifo_full = 1'b0;
    step_state("p0_laf2", 4'd5);
    bus.parity_done = 1'b1;
    step_state("laf_da", 4'd0);
    bus.parity_done  = 1'b0;
    bus.packet_valid = 1'b0;

    // CPE with a full FIFO goes to the stall state
    bus.packet_valid = 1'b1;
    bus.data_in      = 2'd0;
    step_state("c_lfd", 4'd1);
    step_state("c_ld", 4'd2);
    bus.packet_valid = 1'b0;
    step_state("c_lp", 4'd6);
    bus.fifo_full = 1'b1;
    step_state("c_cpe", 4'd7);
    step_state("cpe_ffs", 4'd4);
    bus.fifo_full   = 1'b0;
    bus.parity_done = 1'b1;
    step_state("c_laf", 4'd5);
    step_state("c_da", 4'd0);
    bus.parity_done = 1'b0;

    // Soft reset aborts mid-packet
    bus.packet_valid = 1'b1;
    bus.data_in      = 2'd1;
    step_state("s_lfd", 4'd1);
    step_state("s_ld", 4'd2);
    bus.soft_reset_1 = 1'b1;
    #1 check("s_next_ignored", 32'(bus.next_state), 2);
    step_state("soft_da", 4'd0);
    bus.soft_reset_1 = 1'b0;
    bus.packet_valid = 1'b0;
    step_state("soft_idle", 4'd0);

    // Synchronous reset mid-packet
    bus.packet_valid = 1'b1;
    bus.data_in      = 2'd2;
    step_state("r_lfd", 4'd1);
    step_state("r_ld", 4'd2);
    resetn = 1'b0;
    step_state("rst_mid", 4'd0);
    resetn           = 1'b1;
    bus.packet_valid = 1'b0;

    // Invalid address 3 stays in DA
    bus.packet_valid = 1'b1;
    bus.data_in      = 2'd3;
    step_state("inv_da", 4'd0);
    check("inv_busy", 32'(bus.busy), 0);
    check("inv_detect", 32'(bus.detect_add), 1);
    step_state("inv_hold", 4'd0);

    idle_inputs();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
